// File: rtl/cpu_multicycle_param.sv
// cpu_multicycle_param
//   Parametrised multi-cycle 8-bit-instruction CPU (FETCH/EXEC/MEMRD/WB) with a
//   valid/ready instruction fetch and an optional multiplexed 7-segment display
//   of the last value written back to a register.
//
//   Instruction: op=[7:6] rs=[5:4] rt=[3:2] rd=[1:0]
//     00 ADD  R[rd] <- R[rs]+R[rt]
//     01 LW   R[rd] <- dmem[(R[rs]+R[rt]) mod DMEM_DEPTH]
//     10 SW   dmem[(R[rs]+R[rt]) mod DMEM_DEPTH] <- R[rd]
//     11 JMP  PC <- PC + sext(instr[5:0])
//
//   Ports:
//     clk, reset        clock; synchronous active-high reset
//     instruction       fetched instruction, taken when instr_req & instr_valid
//     instr_valid       fetch source holds the instruction at Read_Address
//     Read_Address      current PC
//     instr_req         high while waiting in FETCH
//     retired           one-cycle pulse after an instruction completes
//     last_wb           last value written to a register (ADD / LW)
//     seg, an           active-low segments {g..a} and digit enables
//
//   Macro CPU_DISPLAY_EN: when defined, the digit scanner and hex decoder are
//   built; otherwise the display is held blank (seg all ones, an all ones).
module cpu_multicycle_param #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DMEM_DEPTH  = 16,
  parameter int NUM_DIGITS  = 2,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            instruction,
  input  logic                  instr_valid,
  output logic [ADDR_W-1:0]     Read_Address,
  output logic                  instr_req,
  output logic                  retired,
  output logic [DATA_W-1:0]     last_wb,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  if (DATA_W < 4 || ADDR_W < 6 || NUM_DIGITS < 1 || NUM_DIGITS > 8 ||
      REFRESH_DIV < 1 || DMEM_DEPTH < 2 ||
      (DMEM_DEPTH & (DMEM_DEPTH - 1)) != 0) begin : g_bad_params
    $error("cpu_multicycle_param: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEMRD, S_WB} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_LW, OP_SW, OP_JMP} op_t;

  localparam int DMEM_AW = $clog2(DMEM_DEPTH);

  state_t            state;
  logic [7:0]        ir;
  logic [DATA_W-1:0] rf   [4];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];
  logic [DATA_W-1:0] mem_rdata;

  op_t                op;
  logic [1:0]         rs, rt, rd;
  logic [DATA_W-1:0]  alu_sum;
  logic [DMEM_AW-1:0] mem_addr;
  logic signed [5:0]  jmp_off;
  logic [ADDR_W-1:0]  jmp_off_ext;
  logic [ADDR_W-1:0]  pc_next;
  logic               retire_now;

  assign op          = op_t'(ir[7:6]);
  assign rs          = ir[5:4];
  assign rt          = ir[3:2];
  assign rd          = ir[1:0];
  assign alu_sum     = rf[rs] + rf[rt];
  // Power-of-two depth: taking the low bits is the modulo.
  assign mem_addr    = alu_sum[DMEM_AW-1:0];
  assign jmp_off     = ir[5:0];
  assign jmp_off_ext = ADDR_W'(jmp_off);   // sign-extends the 6-bit offset
  assign pc_next     = Read_Address + ((op == OP_JMP) ? jmp_off_ext : ADDR_W'(1));
  // LW finishes in WB; every other opcode finishes in EXEC.
  assign retire_now  = ((state == S_EXEC) && (op != OP_LW)) || (state == S_WB);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_FETCH;
      instr_req    <= 1'b1;
      Read_Address <= '0;
      retired      <= 1'b0;
      last_wb      <= '0;
      ir           <= '0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      retired <= retire_now;
      unique case (state)
        S_FETCH: if (instr_valid) begin
          ir        <= instruction;
          state     <= S_EXEC;
          instr_req <= 1'b0;
        end
        S_EXEC: if (op == OP_ADD) begin
          rf[rd]  <= alu_sum;
          last_wb <= alu_sum;
        end else if (op == OP_LW) begin
          state <= S_MEMRD;
        end
        S_MEMRD: state <= S_WB;
        S_WB: begin
          rf[rd]  <= mem_rdata;
          last_wb <= mem_rdata;
        end
        default: state <= S_FETCH;
      endcase
      if (retire_now) begin
        Read_Address <= pc_next;
        state        <= S_FETCH;
        instr_req    <= 1'b1;
      end
    end
  end

  // NOTE: dmem deliberately has no reset; program data survives a CPU reset and
  // the array maps onto plain RAM. Reset still blocks the store.
  always_ff @(posedge clk) begin
    if (!reset && state == S_EXEC && op == OP_SW) dmem[mem_addr] <= rf[rd];
    if (state == S_EXEC) mem_rdata <= dmem[mem_addr];
  end

`ifdef CPU_DISPLAY_EN
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // Zero-padded copy of last_wb so digits beyond DATA_W read as 0.
  localparam int PAD_W = (4 * NUM_DIGITS > DATA_W) ? 4 * NUM_DIGITS : DATA_W;

  logic [DIV_W-1:0] div_cnt;
  logic [DIG_W-1:0] digit;
  logic [PAD_W-1:0] wb_pad;
  logic [3:0]       nibble;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      digit   <= '0;
    end else if (div_cnt == DIV_W'(REFRESH_DIV - 1)) begin
      div_cnt <= '0;
      digit   <= (digit == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit + DIG_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign wb_pad = PAD_W'(last_wb);
  assign nibble = wb_pad[{digit, 2'b00} +: 4];

  // NOTE: each always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    an        = '1;
    an[digit] = 1'b0;
  end

  always_comb begin
    seg = 7'b1111111;
    unique case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end
`else
  assign seg = 7'b1111111;
  assign an  = '1;
`endif

endmodule

// File: tb/tb_cpu_multicycle_param.sv
// Bench for cpu_multicycle_param: directed instruction sequences, an ISA-level
// model updated on each retire pulse, and a per-cycle compare process.
module tb_cpu_multicycle_param;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 16;
  localparam int ND    = 2;
  localparam int RDIV  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    instruction = '0;
  logic          instr_valid = 1'b0;
  logic [AW-1:0] Read_Address;
  logic          instr_req;
  logic          retired;
  logic [DW-1:0] last_wb;
  logic [6:0]    seg;
  logic [ND-1:0] an;

  cpu_multicycle_param #(
    .DATA_W(DW), .ADDR_W(AW), .DMEM_DEPTH(DEPTH), .NUM_DIGITS(ND), .REFRESH_DIV(RDIV)
  ) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
    .Read_Address(Read_Address), .instr_req(instr_req), .retired(retired),
    .last_wb(last_wb), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ISA-level reference model
  typedef struct { logic [7:0] ins; int cyc; } issue_t;
  issue_t q[$];
  int m_rf [4];
  int m_dmem [DEPTH];
  int m_pc;
  int m_last_wb;
  int cyc = 0;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 0;
    m_pc      = 0;
    m_last_wb = 0;
    q.delete();
  endtask

  task automatic model_step(input logic [7:0] ins);
    int s, a, off;
    s = (m_rf[ins[5:4]] + m_rf[ins[3:2]]) % (1 << DW);
    a = s % DEPTH;
    case (ins[7:6])
      2'b00: begin m_rf[ins[1:0]] = s; m_last_wb = s; end
      2'b01: begin m_rf[ins[1:0]] = m_dmem[a]; m_last_wb = m_dmem[a]; end
      2'b10: m_dmem[a] = m_rf[ins[1:0]];
      default: ;
    endcase
    if (ins[7:6] == 2'b11) begin
      off  = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
      m_pc = (m_pc + off + (1 << AW)) % (1 << AW);
    end else begin
      m_pc = (m_pc + 1) % (1 << AW);
    end
  endtask

  task automatic preload(input int addr, input int val);
    m_dmem[addr]   = val;
    dut.dmem[addr] = DW'(val);
  endtask

  // Compare process: outputs sampled on the falling edge.
  initial begin : compare
    issue_t it;
    bit after_reset;
    after_reset = 1'b1;
    model_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (after_reset) begin
        check("rst_pc", 32'(Read_Address), 0);
        check("rst_req", 32'(instr_req), 1);
        check("rst_retired", 32'(retired), 0);
        check("rst_last_wb", 32'(last_wb), 0);
`ifdef CPU_DISPLAY_EN
        check("rst_an", 32'(an), 32'(2'b10));
        check("rst_seg", 32'(seg), 32'(7'b1000000));
`else
        check("rst_an", 32'(an), 32'(2'b11));
        check("rst_seg", 32'(seg), 32'(7'b1111111));
`endif
      end else begin
        if (retired) begin
          if (q.size() == 0) begin
            check("spurious_retire", 32'(retired), 0);
          end else begin
            it = q.pop_front();
            model_step(it.ins);
            check("latency", 32'(cyc - it.cyc), (it.ins[7:6] == 2'b01) ? 4 : 2);
          end
        end
        check("pc", 32'(Read_Address), 32'(m_pc));
        check("last_wb", 32'(last_wb), 32'(m_last_wb));
        check("instr_req", 32'(instr_req), 32'(q.size() == 0));
      end
      after_reset = reset;
      if (reset) model_reset();
      else if (instr_req && instr_valid) q.push_back('{ins: instruction, cyc: cyc});
    end
  end

  // Issue one instruction and wait for its retire pulse; call at posedge+#1.
  task automatic run(input logic [7:0] ins);
    int n;
    n = 0;
    while (!instr_req && n < 20) begin @(posedge clk); #1; n++; end
    check("fetch_wait", 32'(instr_req), 1);
    instruction = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    n = 0;
    while (!retired && n < 20) begin @(posedge clk); #1; n++; end
    check("retire_wait", 32'(retired), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [ND-1:0] prev_an;
    int last_chg, n_chg;

    preload(0, 8'h01);
    preload(1, 8'hF0);
    preload(2, 8'h20);
    preload(4, 8'h03);
    preload(6, 8'h3A);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle fetch: no instruction offered for 10 cycles.
    repeat (10) begin @(posedge clk); #1; end
    check("idle_pc", 32'(Read_Address), 0);
    check("idle_req", 32'(instr_req), 1);

    // ADD wrap: R1=0xF0, R2=0x20, R3 <- R1+R2 = 0x10.
    run(8'h43);   // LW R3 <- [R0+R0]       = 1
    run(8'h71);   // LW R1 <- [R3+R0]       = 0xF0
    run(8'h7E);   // LW R2 <- [R3+R3]       = 0x20
    run(8'h1B);   // ADD R3 <- R1+R2
    check("add_wrap_wb", 32'(last_wb), 32'h10);
    check("add_wrap_pc", 32'(Read_Address), 4);

    // SW/LW round trip and address aliasing (35 mod 16 = 3).
    do_reset();
    run(8'h43);   // R3 = 1
    run(8'h3F);   // ADD R3 <- R3+R3 = 2
    run(8'h7D);   // LW R1 <- [4] = 3
    run(8'h70);   // LW R0 <- [2] = 0x20
    run(8'h98);   // SW [R1+R2=3] <- R0
    run(8'h5B);   // LW R3 <- [3]
    check("sw_lw_wb", 32'(last_wb), 32'h20);
    run(8'h9D);   // SW [R1+R3=35] <- R1 (=3)
    run(8'h52);   // LW R2 <- [R1+R0=35]
    check("alias_wb", 32'(last_wb), 32'h03);

    // Jumps: backward, wrap below 0, self-loop, wrap above 0xFF.
    do_reset();
    run(8'h00);
    run(8'h00);
    run(8'hFE);   // PC 2 + (-2)
    check("jmp_back", 32'(Read_Address), 0);
    run(8'hFF);   // PC 0 + (-1)
    check("jmp_neg_wrap", 32'(Read_Address), 32'hFF);
    run(8'hC0);
    check("jmp_self", 32'(Read_Address), 32'hFF);
    run(8'hC1);   // PC 0xFF + 1
    check("jmp_pos_wrap", 32'(Read_Address), 0);
    run(8'hFF);
    run(8'h00);   // non-jump at 0xFF wraps to 0
    check("seq_wrap", 32'(Read_Address), 0);

    // Reset while an LW to R2 sits in MEMRD.
    do_reset();
    instruction = 8'h42;   // LW R2 <- [0]
    instr_valid = 1'b1;
    @(posedge clk); #1;    // EXEC
    instr_valid = 1'b0;
    @(posedge clk); #1;    // MEMRD
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("memrd_rst_pc", 32'(Read_Address), 0);
    check("memrd_rst_req", 32'(instr_req), 1);
    check("memrd_rst_retired", 32'(retired), 0);
    repeat (3) begin @(posedge clk); #1; end
    run(8'h23);            // ADD R3 <- R2+R0
    check("memrd_rst_r2", 32'(last_wb), 0);

    // Display of last_wb = 0x3A.
    do_reset();
    run(8'h41);   // R1 = 1
    run(8'h15);   // R1 = 2
    run(8'h16);   // R2 = 4
    run(8'h5B);   // R3 <- [6] = 0x3A
    check("disp_wb", 32'(last_wb), 32'h3A);
    prev_an  = an;
    last_chg = -1;
    n_chg    = 0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
`ifdef CPU_DISPLAY_EN
      check("an_onehot", 32'(an == 2'b10 || an == 2'b01), 1);
      check("seg_digit", 32'(seg), (an == 2'b10) ? 32'(7'b0001000) : 32'(7'b0110000));
      if (an != prev_an) begin
        if (last_chg >= 0) check("scan_period", 32'(k - last_chg), RDIV);
        last_chg = k;
        n_chg++;
      end
      prev_an = an;
`else
      check("blank_seg", 32'(seg), 32'(7'b1111111));
      check("blank_an", 32'(an), 32'(2'b11));
`endif
    end
`ifdef CPU_DISPLAY_EN
    check("scan_changes", 32'(n_chg >= 5), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
